// File: rtl/serial_sub4.sv
// Bit-serial subtractor: computes a - b - bin LSB-first through one full-subtractor
// cell, one bit per clock, with a start/done handshake and a registered result.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;

    logic             diff_bit;
    logic             brw_next;
    logic [WIDTH-1:0] r_shifted;

    // Full-subtractor cell on the current LSBs.
    assign diff_bit  = a_q[0] ^ b_q[0] ^ brw_q;
    assign brw_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    assign r_shifted = {diff_bit, r_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_d   = r_shifted;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = brw_next;
                cnt_d = cnt_q + CW'(1);
                // Result becomes visible only once all bits are in.
                if (cnt_q == LAST_CNT) begin
                    d_d     = r_shifted;
                    bout_d  = brw_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    assign d         = d_q;
    assign bout      = bout_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_sub4.sv
// Directed bench for serial_sub4: reset, latency/handshake, wrap cases,
// mid-op reset and an exhaustive back-to-back sweep with start held high.
module tb_serial_sub4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bout;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    serial_sub4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .d         (d),
        .bout      (bout),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one op from IDLE, then follows it to completion with a cycle budget.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                          input logic [3:0] ed, input logic eb, input string tag);
        logic [3:0] prev_d;
        logic       seen;
        logic       stable;
        int         n;
        int         busy_cnt;
        prev_d   = d;
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        n        = 1;
        seen     = 1'b0;
        stable   = 1'b1;
        busy_cnt = 0;
        while (!seen && n <= 10) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (d !== prev_d) stable = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_latency"}, seen ? n : 0, 5);
        check({tag, "_d"}, {28'd0, d}, {28'd0, ed});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        check({tag, "_d_stable"}, {31'd0, stable}, 32'd1);
        check({tag, "_busy_cycles"}, busy_cnt, 5);
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [3:0] held_d;
        logic [4:0] expv;
        int         done_cnt;
        int         wait_n;

        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;

        // Asynchronous reset mid-cycle, observed before any clock edge.
        #13 rst_n = 1'b0;
        #1;
        check("reset_outputs", {24'd0, d, bout, busy, done, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_idle_hold", {24'd0, d, bout, busy, done, dbg_state}, 32'd0);

        // Basic and wrap cases
        run_op(4'b1001, 4'b0011, 1'b0, 4'b0110, 1'b0, "basic");
        run_op(4'b0011, 4'b1001, 1'b0, 4'b1010, 1'b1, "neg");
        run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, "zero_bin");
        run_op(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "ones_bin");
        run_op(4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, "equal");

        // Held result through IDLE
        repeat (3) @(negedge clk);
        check("hold_idle_d", {28'd0, d}, 32'd0);

        // start re-asserted during RUN is ignored
        a = 4'b1000; b = 4'b0010; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'b0001; b = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        held_d   = d;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                done_cnt++;
                check("hs_d", {28'd0, d}, 32'd6);
                check("hs_bout", {31'd0, bout}, 32'd0);
            end else if (busy) begin
                check("hs_d_stable", {28'd0, d}, {28'd0, held_d});
            end
            @(negedge clk);
        end
        check("hs_one_done", done_cnt, 1);

        // Reset two cycles after start aborts the op.
        a = 4'b1100; b = 4'b0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {24'd0, d, bout, busy, done, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("midrst_no_done", done_cnt, 0);
        run_op(4'b1100, 4'b0001, 1'b0, 4'b1011, 1'b0, "after_rst");

        // Exhaustive sweep, start held high, operands refreshed at each done.
        start = 1'b1;
        for (int k = 0; k < 512; k++) begin
            bin  = k[8];
            a    = k[7:4];
            b    = k[3:0];
            expv = {(a < ({1'b0, b} + {4'd0, bin})), 4'(a - b - {3'd0, bin})};
            exp_q.push_back(expv);
            @(negedge clk);
            wait_n = 0;
            while (!done && wait_n < 10) begin
                @(negedge clk);
                wait_n++;
            end
            check("sweep_done_seen", {31'd0, done}, 32'd1);
            if (!done) begin
                $display("FAIL sweep_timeout: no done for combo %0d", k);
                break;
            end
            expv = exp_q.pop_front();
            check("sweep_result", {27'd0, bout, d}, {27'd0, expv});
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("sweep_end_idle", {30'd0, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
